vga_scan_out: RTL and testbench
===============================

Name: vga_scan_out

Overview:
Display output stage downstream of the scanline renderer. Accepts RGB565 pixels through a FIFO write port (`fifo_write`, `fifo_data`, `fifo_full`), buffers them in an internal single-clock FIFO, and generates 640x480 VGA timing. Pops one pixel per active pixel slot and drives registered sync and colour outputs. Issues the one-cycle `trigger` that starts the renderer's frame.

Parameters:
- `H_VISIBLE`, 640, active pixels per line
- `H_FRONT`, 16, horizontal front porch (pixels)
- `H_SYNC`, 96, hsync width (pixels)
- `H_BACK`, 48, horizontal back porch (pixels)
- `V_VISIBLE`, 480, active lines
- `V_FRONT`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vsync width (lines)
- `V_BACK`, 33, vertical back porch (lines)
- `FIFO_AW`, 10, FIFO address width; depth = 2^FIFO_AW
- `FULL_MARGIN`, 4, `fifo_full` asserts at count >= depth - FULL_MARGIN

Ports:
- `clk`  in  1  system clock; the only clock
- `rst`  in  1  synchronous, active-high reset
- `pix_en`  in  1  pixel-rate strobe; timing advances only when high
- `fifo_write`  in  1  push `fifo_data` this cycle
- `fifo_data`  in  16  RGB565 pixel {R5,G6,B5}
- `fifo_full`  out  1  almost-full flag to the producer
- `trigger`  out  1  one-cycle frame-start pulse to the producer
- `hsync`  out  1  horizontal sync, active low
- `vsync`  out  1  vertical sync, active low
- `red`  out  5  colour
- `green`  out  6  colour
- `blue`  out  5  colour
- `underrun`  out  1  sticky: pixel needed while FIFO empty
- `overflow`  out  1  sticky: write arrived while FIFO truly full

Behaviour:
- **Reset.** All of the following take effect on the next clk edge with `rst=1`:
  - `hcnt` = 0 and `vcnt` = 0
  - FIFO empty, count = 0
  - `fifo_full` = 0, `trigger` = 0
  - `hsync` = 1, `vsync` = 1
  - `red`, `green`, `blue` = 0
  - `underrun` = 0, `overflow` = 0
  - Reset mid-frame or mid-write applies the same values; the FIFO contents are discarded.
- **Counters.**
  - `hcnt` spans 0 to H_TOTAL-1, where H_TOTAL = 800.
  - `vcnt` spans 0 to V_TOTAL-1, where V_TOTAL = 525.
  - Both step only on cycles with `pix_en` high.
  - `hcnt` wraps to 0 and increments `vcnt`; `vcnt` wraps at V_TOTAL.
- **Active region.** Active = `hcnt` < H_VISIBLE and `vcnt` < V_VISIBLE.
- **Output registers.** On each `pix_en` cycle the outputs register from the current `hcnt`/`vcnt`. Latency from counter value to pins is 1 clk.
  - `hsync` = 0 iff H_VISIBLE+H_FRONT <= `hcnt` < H_VISIBLE+H_FRONT+H_SYNC, i.e. 656 to 751.
  - `vsync` = 0 iff 490 <= `vcnt` < 492.
  - Active, FIFO non-empty: RGB = FIFO head, and the head is popped in the same cycle.
  - Active, FIFO empty: RGB = 0, no pop, `underrun` set.
  - Blanking: RGB = 0, no pop.
- **FIFO.** First-word-fall-through: the head is valid whenever count > 0.
  - Each write increments the count; each pop decrements it.
  - Write and pop in the same cycle leave the count unchanged.
  - Write when count = depth: data dropped, `overflow` set.
  - `fifo_full` is registered and is 1 iff count >= depth - FULL_MARGIN. The margin absorbs the producer's 2-cycle write pipeline.
- **Trigger and flush.** `trigger` = 1 for exactly one clk, on the `pix_en` cycle where `hcnt`=0 and `vcnt`=V_VISIBLE+V_FRONT (490).
  - In that same cycle the FIFO is flushed: count = 0. A simultaneous write is discarded and does not set `overflow`.
  - The flush realigns any frame damaged by an underrun.
  - The first post-trigger write lands at FIFO index 0 and is shown at (0,0) of the next frame.
- **Width rules.**
  - `hcnt` and `vcnt` are 10 bits.
  - FIFO count is FIFO_AW+1 bits.
  - No arithmetic wraps except the explicit counter wraps.
- **pix_en low.** Counters, sync, RGB and pop hold. FIFO writes and `fifo_full` continue to update every clk.

Decomposition:
- **Shared package** `vga_pkg`:
  - timing constants: H_VISIBLE through V_BACK, H_TOTAL, V_TOTAL
  - RGB565 field widths and slice positions
  - trigger line constant
- **Sub-module** `pixel_fifo`:
  - single-clock FWFT FIFO; ports `clk`, `rst`, `flush`, `wr`, `din`, `rd`, `dout`, `count`, `empty`
  - block-RAM memory with prefetch register
  - `vga_scan_out` instantiates it and owns the timing, flags and output logic.

Test Plan:
- **Reset and timing.** `rst` for 3 clk, then `pix_en`=1 constantly with no writes. Expect `hsync` low for 96 clk starting 657 clk after reset release (656 count plus 1 register), period 800. Expect `vsync` low for 1600 clk, frame period 420000.
- **Trigger.** Expect `trigger` high for exactly 1 clk at (`hcnt`=0, `vcnt`=490), once per frame. A write of 0x1234 on that cycle is dropped: count stays 0 and `overflow` stays 0.
- **Pixel path.** After the trigger, write 307200 pixels (value = index[15:0]) with `pix_en` high. Expect RGB at (0,0) = {0,0,0} and at (1,0) = {00000,000000,00001}. Expect the pixel at (639,479) to be index 307199. Expect `underrun` = 0.
- **Full and overflow.** With `pix_en`=0, write continuously. Expect `fifo_full`=1 once count reaches 1020. Write 1030 words in total: expect count saturated at 1024 and `overflow`=1.
- **Underrun.** Write only 100 pixels before line 0. Expect pixels 100 to 639 of line 0 to be RGB 0 with `underrun`=1. After the next trigger the FIFO is empty and `underrun` stays 1 until `rst`.
- **Reset mid-frame.** Assert `rst` at (`hcnt`=300, `vcnt`=200) with count = 500. Expect counters at 0, count = 0, `hsync`/`vsync` = 1 and `trigger` = 0 on the following clk.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared constants and types for the VGA scan-out stage: 640x480 timing,
// RGB565 layout and the renderer trigger line.
package vga_pkg;

  localparam int H_VISIBLE = 640;
  localparam int H_FRONT   = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BACK    = 48;
  localparam int H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;

  localparam int V_VISIBLE = 480;
  localparam int V_FRONT   = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BACK    = 33;
  localparam int V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam int TRIG_LINE = V_VISIBLE + V_FRONT;

  localparam int CNT_W = 10;
  localparam int PIX_W = 16;
  localparam int R_W   = 5;
  localparam int G_W   = 6;
  localparam int B_W   = 5;
  localparam int R_LSB = 11;
  localparam int G_LSB = 5;
  localparam int B_LSB = 0;

  typedef struct packed {
    logic [R_W-1:0] r;
    logic [G_W-1:0] g;
    logic [B_W-1:0] b;
  } rgb565_t;

endpackage

// File: rtl/pixel_fifo.sv
// Single-clock first-word-fall-through FIFO: synchronous-read RAM whose
// registered output acts as the head prefetch, with a same-address write bypass.
module pixel_fifo
  import vga_pkg::*;
#(
  parameter int AW = 10,
  parameter int DW = PIX_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          wr,
  input  logic [DW-1:0] din,
  input  logic          rd,
  output logic [DW-1:0] dout,
  output logic [AW:0]   count,
  output logic          empty
);

  localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

  logic [DW-1:0] mem_q [2**AW];
  logic [DW-1:0] head_q;
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          wr_ok, rd_ok;

  always_comb begin
    wr_ok  = wr && !flush && (cnt_q != DEPTH);
    rd_ok  = rd && !flush && (cnt_q != '0);
    wptr_d = wptr_q + AW'(wr_ok);
    rptr_d = rptr_q + AW'(rd_ok);
    cnt_d  = cnt_q + (AW+1)'(wr_ok) - (AW+1)'(rd_ok);
    if (flush) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Head register tracks mem[rptr]; a write landing on the next head address
  // must be forwarded because the RAM read returns the old word.
  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wptr_q] <= din;
    head_q <= (wr_ok && (wptr_q == rptr_d)) ? din : mem_q[rptr_d];
  end

  assign dout  = head_q;
  assign count = cnt_q;
  assign empty = (cnt_q == '0);

endmodule

// File: rtl/vga_scan_out.sv
// VGA scan-out: raster counters, registered sync/colour pins, pixel FIFO pop,
// frame trigger with FIFO flush, and sticky underrun/overflow flags.
module vga_scan_out #(
  parameter int H_VISIBLE   = vga_pkg::H_VISIBLE,
  parameter int H_FRONT     = vga_pkg::H_FRONT,
  parameter int H_SYNC      = vga_pkg::H_SYNC,
  parameter int H_BACK      = vga_pkg::H_BACK,
  parameter int V_VISIBLE   = vga_pkg::V_VISIBLE,
  parameter int V_FRONT     = vga_pkg::V_FRONT,
  parameter int V_SYNC      = vga_pkg::V_SYNC,
  parameter int V_BACK      = vga_pkg::V_BACK,
  parameter int FIFO_AW     = 10,
  parameter int FULL_MARGIN = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pix_en,
  input  logic        fifo_write,
  input  logic [15:0] fifo_data,
  output logic        fifo_full,
  output logic        trigger,
  output logic        hsync,
  output logic        vsync,
  output logic [4:0]  red,
  output logic [5:0]  green,
  output logic [4:0]  blue,
  output logic        underrun,
  output logic        overflow
);

  import vga_pkg::*;

  localparam logic [CNT_W-1:0] H_ACT  = CNT_W'(H_VISIBLE);
  localparam logic [CNT_W-1:0] H_SS   = CNT_W'(H_VISIBLE + H_FRONT);
  localparam logic [CNT_W-1:0] H_SE   = CNT_W'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [CNT_W-1:0] V_ACT  = CNT_W'(V_VISIBLE);
  localparam logic [CNT_W-1:0] V_SS   = CNT_W'(V_VISIBLE + V_FRONT);
  localparam logic [CNT_W-1:0] V_SE   = CNT_W'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
  localparam logic [CNT_W-1:0] TRIG_V = CNT_W'(V_VISIBLE + V_FRONT);

  localparam logic [FIFO_AW:0] DEPTH   = {1'b1, {FIFO_AW{1'b0}}};
  localparam logic [FIFO_AW:0] FULL_AT = DEPTH - (FIFO_AW+1)'(FULL_MARGIN);

  logic [CNT_W-1:0] hcnt_q, hcnt_d, vcnt_q, vcnt_d;
  logic             hsync_q, vsync_q, trigger_q, full_q, urun_q, ovf_q;
  rgb565_t          rgb_q, rgb_d;

  logic [PIX_W-1:0] fifo_head;
  logic [FIFO_AW:0] fifo_count, count_nx;
  logic             fifo_empty, active, flush, pop, wr_ok;

  pixel_fifo #(.AW(FIFO_AW), .DW(PIX_W)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .wr    (fifo_write),
    .din   (fifo_data),
    .rd    (pop),
    .dout  (fifo_head),
    .count (fifo_count),
    .empty (fifo_empty)
  );

  always_comb begin
    active = (hcnt_q < H_ACT) && (vcnt_q < V_ACT);
    flush  = pix_en && (hcnt_q == '0) && (vcnt_q == TRIG_V);
    pop    = pix_en && active && !fifo_empty;
    wr_ok  = fifo_write && !flush && (fifo_count != DEPTH);
    rgb_d  = pop ? rgb565_t'(fifo_head) : '0;
    hcnt_d = hcnt_q + 1'b1;
    vcnt_d = vcnt_q;
    if (hcnt_q == H_LAST) begin
      hcnt_d = '0;
      vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + 1'b1;
    end
    // Next FIFO occupancy, so the almost-full flag matches the count it follows.
    count_nx = flush ? '0 : fifo_count + (FIFO_AW+1)'(wr_ok) - (FIFO_AW+1)'(pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hcnt_q    <= '0;
      vcnt_q    <= '0;
      hsync_q   <= 1'b1;
      vsync_q   <= 1'b1;
      rgb_q     <= '0;
      trigger_q <= 1'b0;
      full_q    <= 1'b0;
      urun_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      trigger_q <= flush;
      full_q    <= (count_nx >= FULL_AT);
      ovf_q     <= ovf_q | (fifo_write && !flush && (fifo_count == DEPTH));
      if (pix_en) begin
        hcnt_q  <= hcnt_d;
        vcnt_q  <= vcnt_d;
        hsync_q <= !((hcnt_q >= H_SS) && (hcnt_q < H_SE));
        vsync_q <= !((vcnt_q >= V_SS) && (vcnt_q < V_SE));
        rgb_q   <= rgb_d;
        urun_q  <= urun_q | (active && fifo_empty);
      end
    end
  end

  assign fifo_full = full_q;
  assign trigger   = trigger_q;
  assign hsync     = hsync_q;
  assign vsync     = vsync_q;
  assign red       = rgb_q.r;
  assign green     = rgb_q.g;
  assign blue      = rgb_q.b;
  assign underrun  = urun_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_vga_scan_out.sv
// Bench for vga_scan_out on a shrunken raster: a scoreboard queue holds the
// pixels written, popped as the reference raster reaches active slots.
module tb_vga_scan_out;

  localparam int HV = 8, HF = 2, HS = 3, HB = 2;
  localparam int VV = 4, VF = 2, VS = 1, VB = 2;
  localparam int AW = 4, MARGIN = 4;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;
  localparam int TRIG = VV + VF;
  localparam int DEPTH = 1 << AW;

  logic        clk = 1'b0;
  logic        rst, pix_en, fifo_write;
  logic [15:0] fifo_data;
  logic        fifo_full, trigger, hsync, vsync, underrun, overflow;
  logic [4:0]  red, blue;
  logic [5:0]  green;

  always #5 clk = ~clk;

  vga_scan_out #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .FIFO_AW(AW), .FULL_MARGIN(MARGIN)
  ) dut (
    .clk(clk), .rst(rst), .pix_en(pix_en),
    .fifo_write(fifo_write), .fifo_data(fifo_data), .fifo_full(fifo_full),
    .trigger(trigger), .hsync(hsync), .vsync(vsync),
    .red(red), .green(green), .blue(blue),
    .underrun(underrun), .overflow(overflow)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference raster and scoreboard
  int          mh = 0, mv = 0, pre;
  bit          act, flsh, chk_en = 0;
  logic        exp_hs = 1, exp_vs = 1, exp_trig = 0, exp_full = 0, exp_urun = 0, exp_ovf = 0;
  logic [15:0] exp_rgb = '0;
  logic [15:0] sb[$];

  always @(posedge clk) begin
    if (rst) begin
      mh = 0; mv = 0;
      exp_hs = 1; exp_vs = 1; exp_trig = 0; exp_rgb = '0;
      exp_full = 0; exp_urun = 0; exp_ovf = 0;
      sb.delete();
    end else begin
      pre  = sb.size();
      act  = (mh < HV) && (mv < VV);
      flsh = pix_en && (mh == 0) && (mv == TRIG);
      exp_trig = flsh;
      if (pix_en) begin
        exp_hs = !((mh >= HV + HF) && (mh < HV + HF + HS));
        exp_vs = !((mv >= VV + VF) && (mv < VV + VF + VS));
        if (act && pre > 0) exp_rgb = sb.pop_front();
        else begin
          exp_rgb = '0;
          if (act) exp_urun = 1;
        end
        if (mh == HT - 1) begin
          mh = 0;
          mv = (mv == VT - 1) ? 0 : mv + 1;
        end else mh++;
      end
      if (flsh) sb.delete();
      else if (fifo_write) begin
        if (pre == DEPTH) exp_ovf = 1;
        else sb.push_back(fifo_data);
      end
      exp_full = (sb.size() >= DEPTH - MARGIN);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("hsync", hsync, exp_hs);
      check("vsync", vsync, exp_vs);
      check("trigger", trigger, exp_trig);
      check("rgb", {red, green, blue}, exp_rgb);
      check("fifo_full", fifo_full, exp_full);
      check("underrun", underrun, exp_urun);
      check("overflow", overflow, exp_ovf);
    end
  end

  // Producer: restarts a frame of next_px pixels on each trigger slot
  int idx = 0, wr_left = 0, next_px = 0, frame = 0;
  bit force_wr = 0;

  function automatic logic [15:0] pix_val(input int i, input int f);
    return 16'(i * 16'h0841 + f * 16'h1003 + 16'h0101);
  endfunction

  task automatic step();
    fifo_write = 1'b0;
    if (force_wr) begin
      fifo_write = 1'b1;
      fifo_data  = 16'hF000 + 16'(idx);
      idx++;
    end else if (pix_en && mh == 0 && mv == TRIG) begin
      fifo_write = 1'b1;
      fifo_data  = 16'h1234;
      idx = 0;
      wr_left = next_px;
      frame++;
    end else if (wr_left > 0 && !fifo_full) begin
      fifo_write = 1'b1;
      fifo_data  = pix_val(idx, frame);
      idx++;
      wr_left--;
    end
    @(negedge clk);
  endtask

  task automatic run_to_trig(input string tag);
    int n = 0;
    while (!(pix_en && mh == 0 && mv == TRIG) && n < 400) begin
      step();
      n++;
    end
    if (n >= 400) check({"timeout_", tag}, 32'd1, 32'd0);
  endtask

  initial begin
    int n;
    rst = 1'b1; pix_en = 1'b0; fifo_write = 1'b0; fifo_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_en = 1;
    check("rst_hsync", hsync, 1);
    check("rst_vsync", vsync, 1);
    check("rst_trigger", trigger, 0);
    check("rst_rgb", {red, green, blue}, 0);
    check("rst_full", fifo_full, 0);
    check("rst_underrun", underrun, 0);
    check("rst_overflow", overflow, 0);
    rst = 1'b0;

    // Prefill with the raster held, then stream frame 0
    wr_left = 32; next_px = 32;
    n = 0;
    while (!fifo_full && n < 50) begin
      step();
      n++;
    end
    if (n >= 50) check("timeout_prefill", 32'd1, 32'd0);
    pix_en = 1'b1;
    run_to_trig("f0");
    check("underrun_f0", underrun, 0);
    step();
    check("trig_high", trigger, 1);
    check("trig_write_ovf", overflow, 0);
    check("trig_flush_full", fifo_full, 0);
    step();
    check("trig_low", trigger, 0);

    // Frame 1 fully supplied, frame 2 starved after 5 pixels
    run_to_trig("f1");
    check("underrun_f1", underrun, 0);
    next_px = 5;
    step();
    run_to_trig("f2");
    check("underrun_set", underrun, 1);
    next_px = 0;
    step();
    check("underrun_sticky", underrun, 1);
    check("flush_empty_full", fifo_full, 0);

    // Raster frozen, keep writing past depth
    pix_en = 1'b0;
    force_wr = 1;
    idx = 0;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (i == DEPTH - MARGIN - 1) check("full_below", fifo_full, 0);
      if (i == DEPTH - MARGIN)     check("full_at", fifo_full, 1);
      if (i == DEPTH)              check("ovf_at_depth", overflow, 0);
      if (i == DEPTH + 1)          check("ovf_past_depth", overflow, 1);
    end
    force_wr = 0;
    check("ovf_sticky", overflow, 1);

    // Reset mid-frame with a part-filled FIFO
    pix_en = 1'b1;
    wr_left = 100; frame = 7; idx = 0;
    n = 0;
    while (!(mv == 2 && mh == 3) && n < 400) begin
      step();
      n++;
    end
    if (n >= 400) check("timeout_midframe", 32'd1, 32'd0);
    rst = 1'b1;
    step();
    check("mid_rst_hsync", hsync, 1);
    check("mid_rst_vsync", vsync, 1);
    check("mid_rst_trigger", trigger, 0);
    check("mid_rst_full", fifo_full, 0);
    check("mid_rst_overflow", overflow, 0);
    check("mid_rst_underrun", underrun, 0);
    check("mid_rst_rgb", {red, green, blue}, 0);
    rst = 1'b0;
    wr_left = 0;
    step();
    step();
    check("post_rst_empty", underrun, 1);
    check("post_rst_rgb", {red, green, blue}, 0);

    chk_en = 0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
    $fatal(1, "watchdog");
  end

endmodule
